bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter ADDR_W, default 4, RAM address width.
REQ-002 Parameter DATA_W, default 8, RAM data width.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 reset_n  input  1  synchronous, active-low reset, sampled on posedge clk.
REQ-005 req0, req1  input  1 each  access request; port 0 = CPU, port 1 = program loader.
REQ-006 we0, we1  input  1 each  1 = write, 0 = read, per port.
REQ-007 addr0, addr1  input  ADDR_W each  access address, per port.
REQ-008 wdata0, wdata1  input  DATA_W each  write data, per port.
REQ-009 gnt0, gnt1  output  1 each  port owns the RAM for the current transaction.
REQ-010 ack0, ack1  output  1 each  one-cycle completion pulse, per port.
REQ-011 rdata  output  DATA_W  read data of the completed transaction.
REQ-012 ram_addr  output  ADDR_W  address to the RAM.
REQ-013 ram_we  output  1  RAM write strobe.
REQ-014 ram_wdata  output  DATA_W  write data to the RAM.
REQ-015 ram_rdata  input  DATA_W  combinational (asynchronous) RAM read data.
REQ-016 busy  output  1  high whenever state is not IDLE.

Function
REQ-017 FSM states: IDLE, ACCESS, DONE. Every output is registered.
REQ-018 IDLE, no req: remain in IDLE. gnt*, ack*, ram_we are 0.
REQ-019 IDLE, one req high: grant that port and go to ACCESS on the next edge.
REQ-020 IDLE, both req high: grant the port not granted last (round-robin via a 1-bit last_gnt pointer), then go to ACCESS.
REQ-021 On the grant edge: latch the winner's addr/we/wdata into ram_addr/ram_we/ram_wdata; set gnt of the winner only; update last_gnt to the winner.
REQ-022 ACCESS lasts exactly 1 cycle, with ram_we = latched we.
REQ-023 ACCESS exit edge: capture ram_rdata into rdata (reads only; writes leave rdata unchanged); clear ram_we; pulse the winner's ack; go to DONE.
REQ-024 DONE lasts exactly 1 cycle with ack high. The exit edge clears ack and gnt and returns to IDLE.
REQ-025 Latency: req sampled at edge N gives ACCESS in cycle N..N+1 and ack high in cycle N+1..N+2. Each transaction is 3 cycles including IDLE; back-to-back throughput is 1 access per 3 cycles.
REQ-026 Requesters hold req, we, addr and wdata stable until ack. Inputs changed after the grant edge are ignored for that transaction.
REQ-027 req dropped during ACCESS or DONE: the transaction still completes and ack still pulses.
REQ-028 req still high in the IDLE cycle after DONE: treated as a new request.
REQ-029 Both ports requesting continuously: grants strictly alternate; no port waits more than one transaction.
REQ-030 gnt0 and gnt1, and ack0 and ack1, are never high at the same time.
REQ-031 ram_addr and ram_wdata hold their last values outside transactions; ram_we is high only during ACCESS.

Reset
REQ-032 reset_n low at a posedge: state = IDLE; gnt*, ack*, ram_we, busy = 0; ram_addr, ram_wdata, rdata = 0; last_gnt = 1, so port 0 wins the first tie.
REQ-033 Reset asserted mid-transaction (ACCESS or DONE): the transaction is aborted; no ack is issued; no further ram_we pulse occurs.
REQ-034 Reset has priority over all other transitions.

Verification
REQ-035 Reset then req0 = 1, we0 = 1, addr0 = 3, wdata0 = 0xA5 -> gnt0 = 1 next cycle; ram_we = 1 for exactly 1 cycle with ram_addr = 3 and ram_wdata = 0xA5; ack0 pulses 1 cycle; busy high for 2 cycles.
REQ-036 RAM model holding 0x5C at address 7; req1 = 1, we1 = 0, addr1 = 7 -> ack1 pulse with rdata = 0x5C; ram_we stays 0.
REQ-037 After reset, req0 and req1 raised on the same edge and held -> grant order 0, 1, 0, 1; ack pulses every 3 cycles, alternating ports.
REQ-038 reset_n low during ACCESS of a write -> next cycle all outputs 0 and state IDLE; no ack; ram_we low thereafter.
REQ-039 req0 dropped during ACCESS -> ack0 still pulses in DONE; next IDLE cycle with no req -> no new grant.
REQ-040 addr0 changed during ACCESS -> ram_addr keeps the grant-time value for the whole transaction.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-port round-robin arbiter for a single-port RAM (CPU on port 0, loader on port 1).
// Each transaction takes three cycles: grant in IDLE, one ACCESS cycle, then a DONE cycle with ack.
module bus_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic              last_gnt_r, last_gnt_s;
  logic              winner_s;
  logic              gnt0_r, gnt0_s;
  logic              gnt1_r, gnt1_s;
  logic              ack0_r, ack0_s;
  logic              ack1_r, ack1_s;
  logic              ram_we_r, ram_we_s;
  logic              busy_r, busy_s;
  logic [ADDR_W-1:0] ram_addr_r, ram_addr_s;
  logic [DATA_W-1:0] ram_wdata_r, ram_wdata_s;
  logic [DATA_W-1:0] rdata_r, rdata_s;

  // Next-state and next-output logic; every output is the registered copy of these values.
  always_comb begin
    state_s     = state_r;
    last_gnt_s  = last_gnt_r;
    gnt0_s      = gnt0_r;
    gnt1_s      = gnt1_r;
    ack0_s      = 1'b0;
    ack1_s      = 1'b0;
    ram_we_s    = ram_we_r;
    busy_s      = busy_r;
    ram_addr_s  = ram_addr_r;
    ram_wdata_s = ram_wdata_r;
    rdata_s     = rdata_r;

    // On a tie the port that did not win last time gets the RAM.
    if (req0 && req1) begin
      winner_s = ~last_gnt_r;
    end else if (req1) begin
      winner_s = 1'b1;
    end else begin
      winner_s = 1'b0;
    end

    case (state_r)
      IDLE: begin
        if (req0 || req1) begin
          state_s     = ACCESS;
          gnt0_s      = ~winner_s;
          gnt1_s      = winner_s;
          last_gnt_s  = winner_s;
          ram_addr_s  = winner_s ? addr1  : addr0;
          ram_we_s    = winner_s ? we1    : we0;
          ram_wdata_s = winner_s ? wdata1 : wdata0;
          busy_s      = 1'b1;
        end else begin
          gnt0_s   = 1'b0;
          gnt1_s   = 1'b0;
          ram_we_s = 1'b0;
          busy_s   = 1'b0;
        end
      end
      ACCESS: begin
        // ram_we_r still carries the latched direction during ACCESS.
        if (!ram_we_r) begin
          rdata_s = ram_rdata;
        end else begin
          rdata_s = rdata_r;
        end
        ram_we_s = 1'b0;
        ack0_s   = gnt0_r;
        ack1_s   = gnt1_r;
        busy_s   = 1'b1;
        state_s  = DONE;
      end
      DONE: begin
        gnt0_s   = 1'b0;
        gnt1_s   = 1'b0;
        ram_we_s = 1'b0;
        busy_s   = 1'b0;
        state_s  = IDLE;
      end
      default: begin
        gnt0_s   = 1'b0;
        gnt1_s   = 1'b0;
        ram_we_s = 1'b0;
        busy_s   = 1'b0;
        state_s  = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      last_gnt_r  <= 1'b1;
      gnt0_r      <= 1'b0;
      gnt1_r      <= 1'b0;
      ack0_r      <= 1'b0;
      ack1_r      <= 1'b0;
      ram_we_r    <= 1'b0;
      busy_r      <= 1'b0;
      ram_addr_r  <= {ADDR_W{1'b0}};
      ram_wdata_r <= {DATA_W{1'b0}};
      rdata_r     <= {DATA_W{1'b0}};
    end else begin
      state_r     <= state_s;
      last_gnt_r  <= last_gnt_s;
      gnt0_r      <= gnt0_s;
      gnt1_r      <= gnt1_s;
      ack0_r      <= ack0_s;
      ack1_r      <= ack1_s;
      ram_we_r    <= ram_we_s;
      busy_r      <= busy_s;
      ram_addr_r  <= ram_addr_s;
      ram_wdata_r <= ram_wdata_s;
      rdata_r     <= rdata_s;
    end
  end

  assign gnt0      = gnt0_r;
  assign gnt1      = gnt1_r;
  assign ack0      = ack0_r;
  assign ack1      = ack1_r;
  assign ram_we    = ram_we_r;
  assign busy      = busy_r;
  assign ram_addr  = ram_addr_r;
  assign ram_wdata = ram_wdata_r;
  assign rdata     = rdata_r;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: a transaction-level model plus a RAM, directed scenarios, then random traffic.
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req0, req1, we0, we1;
  logic [3:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       gnt0, gnt1, ack0, ack1, ram_we, busy;
  logic [7:0] rdata, ram_wdata, ram_rdata;
  logic [3:0] ram_addr;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  bus_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
    .rdata(rdata), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
  );

  // Bench RAM driven by the DUT, and the model's own view of memory contents.
  logic [7:0] tb_ram [16];
  logic [7:0] m_mem  [16];
  bit         mem_init = 1'b0;
  assign ram_rdata = tb_ram[ram_addr];

  // Model: a transaction is 0 = not running, 1 = RAM being accessed, 2 = completing with ack.
  int         m_phase = 0;
  bit         m_port = 1'b0;
  bit         m_last = 1'b1;
  logic       m_we = 1'b0;
  logic [3:0] m_addr = 4'd0;
  logic [7:0] m_wdata = 8'd0;
  logic [7:0] m_rdata = 8'd0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // RAM write port plus model update at each clock edge.
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 16; i++) begin
        tb_ram[i] <= 8'(i * 37 + 1);
        m_mem[i]   = 8'(i * 37 + 1);
      end
      tb_ram[7] <= 8'h5C;
      m_mem[7]   = 8'h5C;
      mem_init   = 1'b1;
    end else if (ram_we === 1'b1) begin
      tb_ram[ram_addr] <= ram_wdata;
    end
    if (m_phase == 1 && m_we) m_mem[m_addr] = m_wdata;
    if (!reset_n) begin
      m_phase = 0;
      m_last  = 1'b1;
      m_rdata = 8'd0;
      m_addr  = 4'd0;
      m_wdata = 8'd0;
      m_we    = 1'b0;
    end else if (m_phase == 0) begin
      if (req0 || req1) begin
        m_port  = (req0 && req1) ? !m_last : req1;
        m_we    = m_port ? we1 : we0;
        m_addr  = m_port ? addr1 : addr0;
        m_wdata = m_port ? wdata1 : wdata0;
        m_last  = m_port;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (!m_we) m_rdata = m_mem[m_addr];
      m_phase = 2;
    end else begin
      m_phase = 0;
    end
  end

  // Compare every DUT output against the model once per cycle.
  always @(negedge clk) begin
    if (check_en) begin
      chk("gnt0",      gnt0,      (m_phase != 0) && !m_port);
      chk("gnt1",      gnt1,      (m_phase != 0) && m_port);
      chk("ack0",      ack0,      (m_phase == 2) && !m_port);
      chk("ack1",      ack1,      (m_phase == 2) && m_port);
      chk("ram_we",    ram_we,    (m_phase == 1) && m_we);
      chk("busy",      busy,      m_phase != 0);
      chk("ram_addr",  ram_addr,  m_addr);
      chk("ram_wdata", ram_wdata, m_wdata);
      chk("rdata",     rdata,     m_rdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = 4'd0; addr1 = 4'd0; wdata0 = 8'd0; wdata1 = 8'd0;
    tick();
    check_en = 1'b1;
    chk("reset_busy", busy, 1'b0);
    chk("reset_rdata", rdata, 8'd0);
    chk("reset_ram_addr", ram_addr, 4'd0);

    // Single write from port 0.
    @(negedge clk);
    reset_n = 1'b1; req0 = 1'b1; we0 = 1'b1; addr0 = 4'd3; wdata0 = 8'hA5;
    tick();
    chk("wr_gnt0", gnt0, 1'b1);
    chk("wr_ram_we", ram_we, 1'b1);
    chk("wr_ram_addr", ram_addr, 4'd3);
    chk("wr_ram_wdata", ram_wdata, 8'hA5);
    chk("wr_busy", busy, 1'b1);
    tick();
    chk("wr_ack0", ack0, 1'b1);
    chk("wr_ram_we_off", ram_we, 1'b0);
    chk("wr_busy2", busy, 1'b1);
    @(negedge clk);
    req0 = 1'b0; we0 = 1'b0;
    tick();
    chk("wr_ack0_off", ack0, 1'b0);
    chk("wr_busy_off", busy, 1'b0);

    // Read of address 7 from port 1.
    @(negedge clk);
    req1 = 1'b1; we1 = 1'b0; addr1 = 4'd7;
    tick();
    chk("rd_gnt1", gnt1, 1'b1);
    chk("rd_ram_we", ram_we, 1'b0);
    tick();
    chk("rd_ack1", ack1, 1'b1);
    chk("rd_rdata", rdata, 8'h5C);
    @(negedge clk);
    req1 = 1'b0;
    tick();

    // Reset during the ACCESS cycle of a write.
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 4'd5; wdata0 = 8'h3C;
    tick();
    chk("abort_ram_we", ram_we, 1'b1);
    @(negedge clk);
    reset_n = 1'b0; req0 = 1'b0; we0 = 1'b0;
    tick();
    chk("abort_gnt0", gnt0, 1'b0);
    chk("abort_ack0", ack0, 1'b0);
    chk("abort_ram_we0", ram_we, 1'b0);
    chk("abort_ram_addr", ram_addr, 4'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    chk("abort_no_ack", ack0, 1'b0);
    chk("abort_idle", busy, 1'b0);

    // Both ports requesting continuously: grants alternate starting with port 0.
    @(negedge clk);
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; addr0 = 4'd1; addr1 = 4'd2;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_gnt0", gnt0, (k % 2) == 0);
      chk("rr_gnt1", gnt1, (k % 2) == 1);
      tick();
      chk("rr_ack0", ack0, (k % 2) == 0);
      chk("rr_ack1", ack1, (k % 2) == 1);
      tick();
      chk("rr_idle", busy, 1'b0);
    end
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0;
    tick();

    // req0 dropped during ACCESS; the read of address 3 returns the earlier write.
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; addr0 = 4'd3;
    tick();
    @(negedge clk);
    req0 = 1'b0;
    tick();
    chk("drop_ack0", ack0, 1'b1);
    chk("drop_rdata", rdata, 8'hA5);
    tick();
    chk("drop_ack0_off", ack0, 1'b0);
    tick();
    chk("drop_no_regrant", gnt0, 1'b0);

    // Address changed after the grant edge is ignored.
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; addr0 = 4'd2;
    tick();
    chk("hold_addr_a", ram_addr, 4'd2);
    @(negedge clk);
    addr0 = 4'd9;
    tick();
    chk("hold_addr_b", ram_addr, 4'd2);
    @(negedge clk);
    req0 = 1'b0;
    tick();
    chk("hold_addr_c", ram_addr, 4'd2);

    // Random traffic against the model, with occasional resets.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      reset_n = ($urandom_range(0, 63) != 0);
      req0    = 1'($urandom_range(0, 1));
      req1    = 1'($urandom_range(0, 1));
      we0     = 1'($urandom_range(0, 1));
      we1     = 1'($urandom_range(0, 1));
      addr0   = 4'($urandom_range(0, 15));
      addr1   = 4'($urandom_range(0, 15));
      wdata0  = 8'($urandom_range(0, 255));
      wdata1  = 8'($urandom_range(0, 255));
    end
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0;
    repeat (4) @(negedge clk);
    check_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
